// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch stage between the PC register and decode.
// Assembles four little-endian bytes per instruction and hands them over with valid/ready.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_enable_i,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [7:0]        mem_byte_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   fetch_pc_r, fetch_pc_s;
  logic [1:0]          cnt_r, cnt_s;
  logic [1:0]          cnt_inc_s;
  logic                mem_req_r, mem_req_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic                inst_valid_r, inst_valid_s;
  logic [INST_W-1:0]   inst_r, inst_s;
  logic [ADDR_W-1:0]   inst_pc_r, inst_pc_s;

  // The PC may only advance in the exact cycle decode takes the instruction.
  assign stall_req_o = ~(rdy & (state_r == OUT) & inst_ready_i & ~jump_enable_i);

  assign cnt_inc_s = cnt_r + 2'd1;

  // Next-state and next-output logic; a redirect overrides everything except DRAIN.
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    cnt_s        = cnt_r;
    mem_req_s    = mem_req_r;
    mem_addr_s   = mem_addr_r;
    inst_valid_s = inst_valid_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;

    if (jump_enable_i && (state_r != DRAIN)) begin
      inst_valid_s = 1'b0;
      mem_req_s    = 1'b0;
      // A request the controller has seen but not answered must be swallowed first.
      if ((state_r == REQ) && !mem_valid_i) begin
        state_s = DRAIN;
      end else begin
        state_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          fetch_pc_s = pc_i;
          cnt_s      = 2'd0;
          mem_req_s  = 1'b1;
          mem_addr_s = pc_i;
          state_s    = REQ;
        end
        REQ: begin
          if (mem_valid_i) begin
            case (cnt_r)
              2'd0:    inst_s[7:0]   = mem_byte_i;
              2'd1:    inst_s[15:8]  = mem_byte_i;
              2'd2:    inst_s[23:16] = mem_byte_i;
              2'd3:    inst_s[31:24] = mem_byte_i;
              default: inst_s        = inst_r;
            endcase
            cnt_s = cnt_inc_s;
            if (cnt_r == 2'd3) begin
              mem_req_s    = 1'b0;
              inst_valid_s = 1'b1;
              inst_pc_s    = fetch_pc_r;
              state_s      = OUT;
            end else begin
              mem_addr_s = fetch_pc_r + {{(ADDR_W-2){1'b0}}, cnt_inc_s};
              state_s    = REQ;
            end
          end else begin
            state_s = REQ;
          end
        end
        OUT: begin
          if (inst_ready_i) begin
            inst_valid_s = 1'b0;
            state_s      = IDLE;
          end else begin
            state_s = OUT;
          end
        end
        DRAIN: begin
          mem_req_s = 1'b0;
          if (mem_valid_i) begin
            state_s = IDLE;
          end else begin
            state_s = DRAIN;
          end
        end
        default: begin
          mem_req_s    = 1'b0;
          inst_valid_s = 1'b0;
          state_s      = IDLE;
        end
      endcase
    end
  end

  // State and output registers; rdy low freezes everything, reset wins over rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      fetch_pc_r   <= '0;
      cnt_r        <= 2'd0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
      inst_valid_r <= 1'b0;
      inst_r       <= '0;
      inst_pc_r    <= '0;
    end else if (rdy) begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      cnt_r        <= cnt_s;
      mem_req_r    <= mem_req_s;
      mem_addr_r   <= mem_addr_s;
      inst_valid_r <= inst_valid_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
    end
  end

  assign mem_req_o    = mem_req_r;
  assign mem_addr_o   = mem_addr_r;
  assign inst_valid_o = inst_valid_r;
  assign inst_o       = inst_r;
  assign inst_pc_o    = inst_pc_r;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Consumes the PC produced by the PC register and drives the 1-bit stall back to it.
- Fetches each 32-bit instruction byte-serially through the memory controller's instruction port.
- Presents assembled instructions to decode with a valid/ready handshake.
- Aborts any in-flight fetch on a jump redirect.

Parameters:
- ADDR_W, 32, address and PC width.
- INST_W, 32, instruction width (4 bytes, little-endian).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, all state and outputs are frozen.
- pc_i  in  ADDR_W  current PC from the PC register.
- jump_enable_i  in  1  redirect/flush; same signal that loads the PC register.
- stall_req_o  out  1  1 = PC must hold; 0 = PC advances by 4 this cycle.
- mem_req_o  out  1  byte-read request to the memory controller.
- mem_addr_o  out  ADDR_W  byte address of the request.
- mem_valid_i  in  1  requested byte returned this cycle.
- mem_byte_i  in  8  returned byte.
- inst_valid_o  out  1  assembled instruction available.
- inst_o  out  INST_W  instruction.
- inst_pc_o  out  ADDR_W  PC of inst_o.
- inst_ready_i  in  1  decode accepts the instruction.

Behaviour:
- Reset (rst=1 on a clock edge, takes priority over rdy):
  - State IDLE; byte count 0.
  - mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, stall_req_o=1.
- rdy=0: no state change, outputs hold, mem_valid_i is ignored. The controller never returns a byte while rdy=0.
- States: IDLE, REQ, OUT, DRAIN.
- IDLE:
  - Latch fetch_pc<=pc_i, cnt<=0, go to REQ.
  - stall_req_o=1.
- REQ:
  - mem_req_o=1 and mem_addr_o=fetch_pc+cnt (ADDR_W wrap-around), both registered and stable while waiting.
  - At most one outstanding byte.
  - On mem_valid_i: byte[cnt]<=mem_byte_i (byte0 → bits 7:0, …, byte3 → bits 31:24) and cnt increments.
  - The request address updates in the cycle after a response; the controller may therefore see a new request with no idle gap.
  - When cnt=3 and mem_valid_i=1: go to OUT, mem_req_o<=0.
- OUT:
  - inst_valid_o=1, inst_pc_o=fetch_pc; inst_o held stable until accepted.
  - stall_req_o = ~inst_ready_i (combinational), so the PC increments exactly in the handshake cycle.
  - On handshake: go to IDLE, inst_valid_o<=0.
- Redirect (jump_enable_i=1, priority over every other event except rst):
  - stall_req_o=1 that cycle.
  - An unaccepted instruction is discarded: inst_valid_o<=0, and the instruction is not delivered even if inst_ready_i=1 in the same cycle.
  - If in REQ with a request outstanding and no mem_valid_i this cycle: go to DRAIN and drop mem_req_o.
  - Otherwise go to IDLE.
  - The new PC appears on pc_i in the following cycle; the first fetch after a redirect uses it.
- DRAIN:
  - mem_req_o=0; wait for mem_valid_i, discard the byte, go to IDLE.
  - A further jump_enable_i in DRAIN has no extra effect.
- Timing:
  - With a 1-cycle memory response, best-case PC-to-valid latency is 1 (IDLE) + 4 (REQ) cycles.
  - Throughput is one instruction per 6 cycles, including the handshake cycle.
- Invariants:
  - stall_req_o=0 only in an OUT+ready cycle with no jump.
  - inst_valid_o never asserts in IDLE, REQ or DRAIN.

Test Plan:
- Reset, then pc_i=0x0000_0000, memory bytes 0x13,0x05,0x10,0x00 with 1-cycle response, inst_ready_i=1 → inst_o=0x00100513, inst_pc_o=0 at cycle 5; stall_req_o low exactly that cycle; mem_addr_o sequence 0,1,2,3.
- inst_ready_i=0 for 3 cycles in OUT → inst_o/inst_valid_o stable, stall_req_o=1 throughout; PC advances only on the ready cycle.
- jump_enable_i after 2 bytes of a fetch at 0x100, with a response pending, and pc_i→0x200 → DRAIN swallows the late byte; next requests are 0x200..0x203; nothing from 0x100 is ever valid.
- jump_enable_i in OUT with inst_ready_i=1 → no handshake, stall_req_o=1, refetch from the new pc_i.
- rdy=0 for 4 cycles in mid-REQ (cnt=2) → outputs frozen; on resume, a fetch at 0x1000 completes with the correct bytes.
- pc_i=0xFFFF_FFFE → byte addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1 (wrap); rst asserted mid-fetch → all outputs at their reset values the next cycle.
